block_data_memory: RTL and testbench

Line-granularity backing memory that serves miss fills and write-backs issued by the cache controller. It is a single-outstanding-request responder with a fixed access latency. It sits below the cache and exchanges whole lines (BLOCK_SIZE bytes) per transaction. Ready/valid semantics: mem_ready means "request accepted now"; is_output_valid means "read data present".

---
 rtl/block_data_memory_pkg.sv | 23 ++
 rtl/block_data_memory_mem_delay_counter.sv | 29 ++
 rtl/block_data_memory.sv | 89 ++++++++
 tb/tb_block_data_memory.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/block_data_memory_pkg.sv
// Shared definitions for the line-granularity backing memory:
// FSM encoding, default latency and line/index widths.
package block_data_memory_pkg;

    // FSM encoding kept as plain constants for compatibility with older tools
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam int DEFAULT_MEM_DELAY  = 50;
    localparam int DEFAULT_BLOCK_SIZE = 16;
    localparam int DEFAULT_NUM_BLOCKS = 16384;

    // Widths for the default geometry
    localparam int LINE_BITS   = DEFAULT_BLOCK_SIZE * 8;
    localparam int OFFSET_BITS = $clog2(DEFAULT_BLOCK_SIZE);
    localparam int IDX_BITS    = $clog2(DEFAULT_NUM_BLOCKS);

    // Line width in bits for a given line size in bytes
    function automatic int line_width(input int block_size);
        return block_size * 8;
    endfunction

endpackage

// File: rtl/block_data_memory_mem_delay_counter.sv
// Loadable down-counter that times the fixed access latency.
// Holds at zero once expired; done is asserted while the count is zero.
module mem_delay_counter #(
    parameter int DELAY = 50,
    parameter int CW    = $clog2(DELAY) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [CW-1:0] load_value,
    output logic          done
);

    logic [CW-1:0] cnt;

    // Load has priority; otherwise count down and saturate at zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_value;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/block_data_memory.sv
// Single-outstanding line memory below the cache. Accepts one read or
// write per transaction, completes it DELAY cycles later, then returns
// to idle. Requests seen while busy are dropped, not queued.
module block_data_memory
    import block_data_memory_pkg::*;
#(
    parameter int BLOCK_SIZE = DEFAULT_BLOCK_SIZE,
    parameter int NUM_BLOCKS = DEFAULT_NUM_BLOCKS,
    parameter int DELAY      = DEFAULT_MEM_DELAY
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    is_input_valid,
    input  logic [31:0]             addr,
    input  logic                    mem_read,
    input  logic                    mem_write,
    input  logic [BLOCK_SIZE*8-1:0] din,
    output logic                    is_output_valid,
    output logic [BLOCK_SIZE*8-1:0] dout,
    output logic                    mem_ready
);

    localparam int LW = line_width(BLOCK_SIZE);
    localparam int IW = $clog2(NUM_BLOCKS);
    localparam int CW = $clog2(DELAY) + 1;

    logic [0:0]    state;
    logic          op_read;
    logic [IW-1:0] idx;
    logic [LW-1:0] din_q;
    logic [LW-1:0] mem [NUM_BLOCKS];
    logic          cnt_done;
    logic          accept;
    logic          complete;

    // Address bits above the index only alias onto existing lines
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[31:IW];

    // Exactly one of read/write must be set for a request to be taken
    assign accept    = (state == ST_IDLE) && is_input_valid && (mem_read ^ mem_write);
    assign complete  = (state == ST_BUSY) && cnt_done;
    assign mem_ready = (state == ST_IDLE);

    mem_delay_counter #(
        .DELAY (DELAY),
        .CW    (CW)
    ) u_delay (
        .clk        (clk),
        .reset      (reset),
        .load       (accept),
        .load_value (CW'(DELAY - 1)),
        .done       (cnt_done)
    );

    // FSM, request capture and read-data return
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= ST_IDLE;
            op_read         <= 1'b0;
            idx             <= '0;
            din_q           <= '0;
            dout            <= '0;
            is_output_valid <= 1'b0;
        end else begin
            is_output_valid <= complete && op_read;
            if (accept) begin
                state   <= ST_BUSY;
                op_read <= mem_read;
                idx     <= addr[IW-1:0];
                din_q   <= din;
            end else if (complete) begin
                state <= ST_IDLE;
                if (op_read) begin
                    dout <= mem[idx];
                end
            end
        end
    end

    // Line array commit; not cleared by reset. A reset forces the FSM
    // idle, so an in-flight write never reaches this point.
    always_ff @(posedge clk) begin
        if (complete && !op_read) begin
            mem[idx] <= din_q;
        end
    end

endmodule

// File: tb/tb_block_data_memory.sv
// Directed bench for block_data_memory (16-byte lines, 256 lines, DELAY=4).
// Read requests push their expected line into a queue; a monitor pops and
// compares whenever a read pulse appears.
module tb_block_data_memory;

    localparam int DLY = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         is_input_valid = 1'b0;
    logic [31:0]  addr = '0;
    logic         mem_read = 1'b0;
    logic         mem_write = 1'b0;
    logic [127:0] din = '0;
    logic         is_output_valid;
    logic [127:0] dout;
    logic         mem_ready;

    int checks = 0;
    int errors = 0;

    logic [127:0] exp_q [$];
    logic [127:0] ref_mem [256];
    logic [127:0] last_read = '0;

    block_data_memory #(
        .BLOCK_SIZE (16),
        .NUM_BLOCKS (256),
        .DELAY      (DLY)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .is_input_valid  (is_input_valid),
        .addr            (addr),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .din             (din),
        .is_output_valid (is_output_valid),
        .dout            (dout),
        .mem_ready       (mem_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every read pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (is_output_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got dout %h expected no pulse", dout);
            end else begin
                last_read = exp_q.pop_front();
                chk("read_data", dout, last_read);
                chk("ready_with_pulse", {127'b0, mem_ready}, 128'd1);
            end
        end
    end

    // Issue one request at a negedge and let it be sampled at the next posedge
    task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [127:0] d);
        @(negedge clk);
        is_input_valid = 1'b1;
        mem_read       = rd;
        mem_write      = wr;
        addr           = a;
        din            = d;
        @(posedge clk);
        #1;
        is_input_valid = 1'b0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
    endtask

    // Count cycles with mem_ready low after an acceptance (bounded)
    task automatic busy_len(output int n);
        n = 0;
        while (mem_ready == 1'b0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    // Full accepted transaction with model update and busy-length check
    task automatic xact(input logic rd, input logic [31:0] a, input logic [127:0] d, input string name);
        int n;
        if (rd) exp_q.push_back(ref_mem[a[7:0]]);
        drive(rd, !rd, a, d);
        if (!rd) ref_mem[a[7:0]] = d;
        busy_len(n);
        chk(name, 128'(n), 128'(DLY));
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        // 1: reset and idle
        idle(2);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_ready", {127'b0, mem_ready}, 128'd1);
        chk("rst_valid", {127'b0, is_output_valid}, 128'd0);
        chk("rst_dout", dout, 128'd0);
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (mem_ready !== 1'b1) n++;
        end
        chk("idle_ready_20", 128'(n), 128'd0);

        // 2: write then read line 0x12
        xact(1'b0, 32'h12, 128'h00112233_44556677_8899AABB_CCDDEEFF, "wr12_busy");
        xact(1'b1, 32'h12, 128'h0, "rd12_busy");
        idle(2);
        chk("rd12_dout_hold", dout, 128'h00112233_44556677_8899AABB_CCDDEEFF);

        // 3: read 0x05 with traffic while busy
        xact(1'b0, 32'h05, 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF, "wr05_busy");
        exp_q.push_back(128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF);
        drive(1'b1, 1'b0, 32'h05, 128'h0);
        is_input_valid = 1'b1;
        mem_write      = 1'b1;
        addr           = 32'h05;
        din            = 128'h1111_2222;
        @(posedge clk); #1;
        addr           = 32'h06;
        din            = 128'h3333_4444;
        @(posedge clk); #1;
        is_input_valid = 1'b0;
        mem_write      = 1'b0;
        busy_len(n);
        chk("rd05_busy_rest", 128'(n), 128'(DLY - 2));
        idle(2);
        xact(1'b1, 32'h05, 128'h0, "rd05_again_busy");
        xact(1'b1, 32'h06, 128'h0, "rd06_busy_unused");

        // 4: index wrap, dout must hold across a write
        idle(2);
        xact(1'b0, 32'h112, {16{8'hA5}}, "wr112_busy");
        chk("dout_hold_after_wr", dout, last_read);
        xact(1'b1, 32'h012, 128'h0, "rd012_busy");

        // 5: both read and write set -> ignored
        idle(2);
        drive(1'b1, 1'b1, 32'h12, 128'h0);
        chk("both_ready", {127'b0, mem_ready}, 128'd1);
        drive(1'b0, 1'b0, 32'h12, 128'h0);
        chk("none_ready", {127'b0, mem_ready}, 128'd1);
        idle(DLY + 2);

        // 6: reset aborts an in-flight write
        xact(1'b0, 32'h07, {16{8'h07}}, "wr07_busy");
        drive(1'b0, 1'b1, 32'h07, {16{8'hFF}});
        @(posedge clk); #1;
        reset = 1'b0;
        #2;
        chk("midrst_ready", {127'b0, mem_ready}, 128'd1);
        chk("midrst_valid", {127'b0, is_output_valid}, 128'd0);
        idle(3);
        @(negedge clk);
        reset = 1'b1;
        chk("postrst_dout", dout, 128'd0);
        idle(DLY + 2);
        xact(1'b1, 32'h07, 128'h0, "rd07_busy");
        idle(3);

        chk("queue_drained", 128'(exp_q.size()), 128'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard stop guard
    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
